frame_buffer_ctrl: RTL and testbench
====================================

Name: frame_buffer_ctrl

Overview:
- Single-clock sequencer that owns the frame buffer's port-A write side and its copy handshake.
- Accepts the camera pixel stream (vsync/href/valid/data) and generates w_addr, w_en_a and d_in_a for one complete frame.
- On end-of-frame it checks the pixel count, then drives r_rd and tracks r_done until the A-to-B copy completes.
- Frames that arrive while a copy is in flight are counted as dropped.

Parameters:
- FRAME_PIXELS, 65536: pixels per valid frame; the last address written is FRAME_PIXELS-1.
- ACK_TIMEOUT, 1024: maximum cycles from r_rd rise until r_done must go low.
- DECIM, 1: frame decimation divisor; used only with FRAME_DECIM_EN.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run request.
- cam_vsync  in  1  camera vsync, already synchronous to clk; high = blanking.
- cam_href  in  1  camera line-valid.
- pix_valid  in  1  one-cycle strobe; one 16-bit pixel on pix_data.
- pix_data  in  16  pixel value.
- w_addr  out  16  buffer write address.
- d_in_a  out  16  buffer write data.
- w_en_a  out  1  buffer write enable.
- r_rd  out  1  copy request to buffer; held high for the whole copy.
- r_done  in  1  buffer copy-idle flag; high = idle.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when a copy completes.
- frame_err  out  1  one-cycle pulse on short frame, long frame or handshake timeout.
- drop_cnt  out  8  saturating count of skipped frames.
- state_o  out  3  current state encoding, for LEDs/debug.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; state IDLE; pixel count, timeout counter and vsync history register cleared.
- Edge detection: vsync_q is registered each cycle.
  - Start-of-frame (sof) = vsync_q & !cam_vsync (falling edge).
  - End-of-frame (eof) = !vsync_q & cam_vsync (rising edge).
- State encodings: IDLE=0, WAIT_SOF=1, CAPTURE=2, COPY_REQ=3, COPY_WAIT=4.
- IDLE: go to WAIT_SOF when enable=1.
- WAIT_SOF: on sof, clear pixel count and go to CAPTURE. enable=0 returns to IDLE.
- CAPTURE, write path:
  - Each cycle with cam_href & pix_valid & count < FRAME_PIXELS registers w_en_a=1, d_in_a=pix_data, w_addr=count[15:0], then increments count.
  - Latency is one cycle from pixel in to write out. w_en_a is 0 on all other cycles.
- CAPTURE, overflow: a pixel arriving at count == FRAME_PIXELS is not written and sets an overflow flag.
- CAPTURE, eof:
  - count == FRAME_PIXELS and no overflow: go to COPY_REQ.
  - Otherwise: frame_err pulse, go to WAIT_SOF.
- CAPTURE, enable=0: abort without a copy, go to IDLE, no error pulse.
- COPY_REQ:
  - r_rd=1; the timeout counter increments every cycle.
  - r_done=0 seen: go to COPY_WAIT.
  - Counter reaches ACK_TIMEOUT first: r_rd=0, frame_err pulse, go to WAIT_SOF.
- COPY_WAIT: r_rd stays 1. When r_done=1: r_rd=0, frame_done pulse, go to WAIT_SOF (or IDLE if enable=0).
- enable=0 during either COPY state does not abort; the copy completes first.
- Drop counting: a sof seen in COPY_REQ or COPY_WAIT increments drop_cnt, saturating at 255. That frame is not captured, because capture re-arms only at the next sof after WAIT_SOF is entered.
- Simultaneous sof and eof is impossible with one vsync input. An eof seen in WAIT_SOF is ignored.
- r_rd is deasserted in the same cycle the controller leaves the COPY states. A new r_rd rising edge therefore needs at least one cycle low, which the buffer's edge detector requires.
- Writes are never issued while r_rd=1; this guarantees no port-A conflict with the copy.

Optional Feature:
- Macro: FRAME_DECIM_EN.
- Defined:
  - A frame counter increments on every sof seen in WAIT_SOF.
  - Only a frame whose counter value mod DECIM == 0 enters CAPTURE; other frames stay in WAIT_SOF and count toward drop_cnt.
  - DECIM=1 captures every frame.
- Undefined: no frame counter logic is built; every sof in WAIT_SOF starts capture.

Test Plan (bench uses FRAME_PIXELS=16, ACK_TIMEOUT=8 unless noted):
- Reset and idle check:
  - Stimulus: enable=1; vsync low, then high, then low; 16 pixels of values 0x1000..0x100F with href=1; vsync rises.
  - Required: 16 writes at w_addr 0..15 with matching data, one cycle after each pixel; then r_rd=1.
  - Buffer model pulls r_done low after 3 cycles and high after 20 cycles. Required: r_rd falls and frame_done pulses once.
- Short frame: only 10 pixels, then eof -> frame_err pulse; r_rd never asserts; state_o returns to 1.
- Long frame: 18 pixels -> exactly 16 writes; addresses 16 and 17 are never issued; eof -> frame_err; no copy.
- Timeout: r_done held high after r_rd rises -> r_rd drops after 8 cycles, frame_err pulses, state_o=1.
- Drop during copy: 3 sof edges while r_done is held low -> drop_cnt=3; after r_done rises, the next frame captures normally.
- Enable and reset mid-operation:
  - enable dropped at pixel 5 -> IDLE with no writes thereafter.
  - rst_n pulsed low during COPY_WAIT -> r_rd=0, drop_cnt=0 and state_o=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/frame_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : frame_buffer_ctrl
//  Description : Port-A write sequencer and copy handshake for the frame
//                buffer. Captures one camera frame (vsync/href/valid/data),
//                writes it linearly from address 0, verifies the pixel count
//                at end-of-frame, then raises r_rd and tracks r_done until
//                the A-to-B copy finishes. Frames arriving during a copy are
//                counted as dropped.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional macro : FRAME_DECIM_EN - capture only every DECIM-th frame.
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   system clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    enable     in   run request
//    cam_vsync  in   camera vsync (synchronous to clk), high = blanking
//    cam_href   in   camera line-valid
//    pix_valid  in   pixel strobe
//    pix_data   in   16-bit pixel value
//    w_addr     out  buffer write address
//    d_in_a     out  buffer write data
//    w_en_a     out  buffer write enable
//    r_rd       out  copy request, high for the whole copy
//    r_done     in   buffer copy-idle flag, high = idle
//    busy       out  controller not in IDLE
//    frame_done out  one-cycle pulse when a copy completes
//    frame_err  out  one-cycle pulse on short/long frame or ack timeout
//    drop_cnt   out  saturating count of skipped frames
//    state_o    out  current state encoding
// ============================================================================
module frame_buffer_ctrl #(
  parameter int FRAME_PIXELS = 65536,
  parameter int ACK_TIMEOUT  = 1024,
  parameter int DECIM        = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  output logic [15:0] w_addr,
  output logic [15:0] d_in_a,
  output logic        w_en_a,
  output logic        r_rd,
  input  logic        r_done,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err,
  output logic [7:0]  drop_cnt,
  output logic [2:0]  state_o
);

  localparam int c_cnt_w = $clog2(FRAME_PIXELS + 1);
  localparam int c_tmo_w = $clog2(ACK_TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(FRAME_PIXELS);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SOF  = 3'd1,
    CAPTURE   = 3'd2,
    COPY_REQ  = 3'd3,
    COPY_WAIT = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_vsync_q;
  logic [c_cnt_w-1:0]   r_count;
  logic                 r_ovf;
  logic [c_tmo_w-1:0]   r_tmo;
  logic [15:0]          r_addr;
  logic [15:0]          r_data;
  logic                 r_we;
  logic                 r_done_p;
  logic                 r_err_p;
  logic [7:0]           r_drop;

  logic w_sof, w_eof, w_in_copy, w_decim_pass, w_drop;
  logic w_start, w_err, w_done;

  assign w_sof     = r_vsync_q & ~cam_vsync;
  assign w_eof     = ~r_vsync_q & cam_vsync;
  assign w_in_copy = (r_state == COPY_REQ) || (r_state == COPY_WAIT);

`ifdef FRAME_DECIM_EN
  // Wrapping counter 0..DECIM-1 is equivalent to "frame number mod DECIM".
  localparam int c_dec_w = (DECIM > 1) ? $clog2(DECIM) : 1;
  logic [c_dec_w-1:0] r_dec_cnt;

  assign w_decim_pass = (r_dec_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec_cnt <= '0;
    end else if (r_state == WAIT_SOF && enable && w_sof) begin
      r_dec_cnt <= (r_dec_cnt == c_dec_w'(DECIM - 1)) ? '0 : r_dec_cnt + 1'b1;
    end
  end
`else
  assign w_decim_pass = 1'b1;
`endif

  // Frames skipped while a copy owns the buffer, or rejected by decimation.
  assign w_drop = (w_sof & w_in_copy) |
                  (w_sof & enable & (r_state == WAIT_SOF) & ~w_decim_pass);

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_err   = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) w_next = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (!enable) begin
          w_next = IDLE;
        end else if (w_sof && w_decim_pass) begin
          w_start = 1'b1;
          w_next  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!enable) begin
          w_next = IDLE;
        end else if (w_eof) begin
          if (r_count == c_full && !r_ovf) begin
            w_next = COPY_REQ;
          end else begin
            w_err  = 1'b1;
            w_next = WAIT_SOF;
          end
        end
      end
      COPY_REQ: begin
        if (!r_done) begin
          w_next = COPY_WAIT;
        end else if (r_tmo == c_tmo_last) begin
          w_err  = 1'b1;
          w_next = WAIT_SOF;
        end
      end
      COPY_WAIT: begin
        if (r_done) begin
          w_done = 1'b1;
          w_next = enable ? WAIT_SOF : IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_vsync_q <= 1'b0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_tmo     <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_we      <= 1'b0;
      r_done_p  <= 1'b0;
      r_err_p   <= 1'b0;
      r_drop    <= '0;
    end else begin
      r_state   <= w_next;
      r_vsync_q <= cam_vsync;
      r_we      <= 1'b0;
      r_done_p  <= w_done;
      r_err_p   <= w_err;

      if (w_start) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (r_state == CAPTURE && enable && !w_eof && cam_href && pix_valid) begin
        // A pixel on the eof cycle itself is ignored so that a write can
        // never land in the first cycle of COPY_REQ while r_rd is high.
        if (r_count < c_full) begin
          r_we    <= 1'b1;
          r_addr  <= 16'(r_count);
          r_data  <= pix_data;
          r_count <= r_count + 1'b1;
        end else begin
          r_ovf <= 1'b1;
        end
      end

      if (r_state == COPY_REQ) r_tmo <= r_tmo + 1'b1;
      else                     r_tmo <= '0;

      if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 1'b1;
    end
  end

  // r_rd decodes directly from the state register so it drops in the very
  // cycle the controller leaves the copy states and clears asynchronously.
  assign r_rd       = w_in_copy;
  assign busy       = (r_state != IDLE);
  assign state_o    = r_state;
  assign w_addr     = r_addr;
  assign d_in_a     = r_data;
  assign w_en_a     = r_we;
  assign frame_done = r_done_p;
  assign frame_err  = r_err_p;
  assign drop_cnt   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_buffer_ctrl
//  Description : Self-checking bench for frame_buffer_ctrl (FRAME_PIXELS=16,
//                ACK_TIMEOUT=8). Stimulus pushes expected writes into a
//                queue; a negedge monitor pops and compares each write and
//                counts handshake pulses. A small buffer model answers r_rd.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_buffer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, enable, cam_vsync, cam_href, pix_valid, r_done;
  logic [15:0] pix_data;
  logic [15:0] w_addr, d_in_a;
  logic        w_en_a, r_rd, busy, frame_done, frame_err;
  logic [7:0]  drop_cnt;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  frame_buffer_ctrl #(.FRAME_PIXELS(16), .ACK_TIMEOUT(8), .DECIM(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .pix_valid(pix_valid), .pix_data(pix_data),
    .w_addr(w_addr), .d_in_a(d_in_a), .w_en_a(w_en_a), .r_rd(r_rd),
    .r_done(r_done), .busy(busy), .frame_done(frame_done),
    .frame_err(frame_err), .drop_cnt(drop_cnt), .state_o(state_o)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_done = 0, n_err = 0, n_rise = 0, rd_len = 0, last_rd_len = 0;
  logic rd_prev = 1'b0;
  int   buf_mode = 0;       // 0: normal ack, 1: never ack, 2: hold busy until release
  logic release_copy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_prev = 1'b0;
      rd_len  = 0;
    end else begin
      if (w_en_a) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: addr %0d data %h, no write expected", w_addr, d_in_a);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("wr_addr", int'(w_addr), int'(e.addr));
          check("wr_data", int'(d_in_a), int'(e.data));
          check("wr_latency_cycle", cyc, e.cyc);
        end
        if (r_rd) begin
          total++;
          bad++;
          $display("FAIL write_during_copy: w_en_a=1 with r_rd=1, required r_rd=0");
        end
      end
      if (frame_done) n_done++;
      if (frame_err)  n_err++;
      if (r_rd && !rd_prev) n_rise++;
      if (r_rd) rd_len++;
      else if (rd_prev) begin
        last_rd_len = rd_len;
        rd_len = 0;
      end
      rd_prev = r_rd;
    end
  end

  // Buffer model answering the copy request
  initial begin
    r_done = 1'b1;
    forever begin
      @(posedge r_rd);
      if (buf_mode == 0) begin
        repeat (3) @(posedge clk);
        #1 r_done = 1'b0;
        repeat (17) @(posedge clk);
        #1 r_done = 1'b1;
      end else if (buf_mode == 2) begin
        repeat (3) @(posedge clk);
        #1 r_done = 1'b0;
        wait (release_copy);
        @(posedge clk);
        #1 r_done = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: vsync blanking, sof, n pixels, eof. enable drops at pixel drop_at.
  task automatic send_frame(input int n, input int base, input int drop_at);
    cam_vsync = 1'b1; tick(); tick();
    cam_vsync = 1'b0; tick();
    for (int i = 0; i < n; i++) begin
      if (i == drop_at) enable = 1'b0;
      cam_href  = 1'b1;
      pix_valid = 1'b1;
      pix_data  = 16'(base + i);
      if (i < 16 && (drop_at < 0 || i < drop_at)) begin
        exp_t e;
        e.addr = 16'(i);
        e.data = 16'(base + i);
        e.cyc  = cyc + 1;
        q.push_back(e);
      end
      tick();
    end
    cam_href  = 1'b0;
    pix_valid = 1'b0;
    tick();
    cam_vsync = 1'b1;
    tick();
  endtask

  task automatic wait_state(input int s, input int max, input string name);
    int n = 0;
    while (int'(state_o) != s && n < max) begin
      tick();
      n++;
    end
    check(name, int'(state_o), s);
  endtask

  task automatic wait_done(input int target, input int max);
    int n = 0;
    while (n_done < target && n < max) begin
      tick();
      n++;
    end
    check("frame_done_count", n_done, target);
  endtask

  initial begin
    int e0, r0, d0;
    rst_n = 1'b0; enable = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0;
    pix_valid = 1'b0; pix_data = '0;
    #3;
    check("rst_state", int'(state_o), 0);
    check("rst_drop", int'(drop_cnt), 0);
    check("rst_flags", int'({w_en_a, r_rd, busy, frame_done, frame_err}), 0);
    check("rst_addr", int'(w_addr), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    enable = 1'b1;
    tick(); tick();
    check("idle_to_wait_sof", int'(state_o), 1);

    // Normal frame and copy
    send_frame(16, 'h1000, -1);
    wait_done(1, 60);
    tick();
    check("t1_queue_empty", q.size(), 0);
    check("t1_err", n_err, 0);
    check("t1_rd_low", int'(r_rd), 0);
    check("t1_rd_rises", n_rise, 1);
    check("t1_state", int'(state_o), 1);

    // Short frame
    e0 = n_err; r0 = n_rise;
    send_frame(10, 'h2000, -1);
    tick(); tick(); tick();
    check("short_err", n_err, e0 + 1);
    check("short_no_copy", n_rise, r0);
    check("short_state", int'(state_o), 1);
    check("short_queue_empty", q.size(), 0);

    // Long frame
    e0 = n_err;
    send_frame(18, 'h3000, -1);
    tick(); tick(); tick();
    check("long_err", n_err, e0 + 1);
    check("long_no_copy", n_rise, r0);
    check("long_queue_empty", q.size(), 0);

    // Handshake timeout
    buf_mode = 1;
    e0 = n_err; d0 = n_done;
    send_frame(16, 'h4000, -1);
    wait_state(1, 40, "tmo_state");
    tick(); tick();
    check("tmo_rd_len", last_rd_len, 8);
    check("tmo_err", n_err, e0 + 1);
    check("tmo_no_done", n_done, d0);
    check("tmo_rd_low", int'(r_rd), 0);

    // Drops while the copy is in flight
    buf_mode = 2; release_copy = 1'b0;
    send_frame(16, 'h5000, -1);
    wait_state(4, 20, "drop_copy_wait");
    for (int k = 0; k < 3; k++) begin
      cam_vsync = 1'b0; tick();
      cam_vsync = 1'b1; tick();
    end
    check("drop_cnt_3", int'(drop_cnt), 3);
    release_copy = 1'b1;
    wait_done(2, 60);
    buf_mode = 0; release_copy = 1'b0;
    send_frame(16, 'h6000, -1);
    wait_done(3, 60);
    check("after_drop_queue_empty", q.size(), 0);

    // Enable dropped mid-capture
    e0 = n_err;
    send_frame(10, 'h7000, 5);
    tick(); tick(); tick();
    check("en_drop_state", int'(state_o), 0);
    check("en_drop_busy", int'(busy), 0);
    check("en_drop_no_err", n_err, e0);
    check("en_drop_queue_empty", q.size(), 0);

    // Asynchronous reset during COPY_WAIT
    enable = 1'b1;
    tick(); tick();
    buf_mode = 2; release_copy = 1'b0;
    send_frame(16, 'h8000, -1);
    wait_state(4, 20, "rst_copy_wait");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rd", int'(r_rd), 0);
    check("async_rst_drop", int'(drop_cnt), 0);
    check("async_rst_state", int'(state_o), 0);
    check("async_rst_queue_empty", q.size(), 0);
    release_copy = 1'b1;
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
